// File: rtl/axis_rs422_tx_gen_if.sv
// axis_rs422_tx_gen_if
// Word feed into the RS-422 transmitter. This is a plain valid/ready stream
// with an end-of-frame marker.
//   s_tvalid : producer has a word on s_tdata / s_tlast
//   s_tready : transmitter accepts the word in this cycle
//   s_tlast  : the word is the last one of the chip-select frame
//   s_tdata  : DATA_W-bit payload word
// The master modport is the word producer. The slave modport is the transmitter.
interface axis_rs422_tx_gen_if #(
   parameter int DATA_W = 8
);
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [DATA_W-1:0] s_tdata;

   modport master (output s_tvalid, output s_tlast, output s_tdata, input s_tready);
   modport slave  (input s_tvalid, input s_tlast, input s_tdata, output s_tready);
endinterface

// File: rtl/axis_rs422_tx_gen.sv
// axis_rs422_tx_gen
// Serialises stream words onto a synchronous RS-422 link made of a clock,
// an active-low chip select and a data line. One frame is a run of words
// ending with tlast. Chip select is asserted CS_SETUP cycles before the
// first bit and is held CS_HOLD cycles after the last bit.
// Ports:
//   clk, rst    : system clock; synchronous active-high reset
//   s_axis      : slave side of the word stream (tvalid/tready/tlast/tdata)
//   rs422_clk   : serial bit clock; idles at CPOL, first half of a bit at !CPOL
//   rs422_cs    : chip select, active low
//   rs422_data  : serial data, held stable for a whole bit period
//   busy        : high whenever a frame is in progress
//   underrun    : one-cycle pulse when a non-final word ran out with no successor
//   frame_done  : one-cycle pulse when a frame has fully completed
module axis_rs422_tx_gen #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter int CS_SETUP  = 50000,
   parameter int CS_HOLD   = 50000,
   parameter int MSB_FIRST = 1,
   parameter int CPOL      = 1
) (
   input  logic               clk,
   input  logic               rst,
   axis_rs422_tx_gen_if.slave s_axis,
   output logic               rs422_clk,
   output logic               rs422_cs,
   output logic               rs422_data,
   output logic               busy,
   output logic               underrun,
   output logic               frame_done
);

   localparam int PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HALF    = PH_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
   localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
   localparam logic             IDLE_CLK   = (CPOL != 0);
   localparam logic             MSB_FST    = (MSB_FIRST != 0);

   typedef enum logic [2:0] {IDLE, SETUP, WAIT, SHIFT, HOLD} state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   tmr, tmr_nxt;
   logic [PH_W-1:0]    phase, phase_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic [DATA_W-1:0]  shreg, shreg_nxt;
   logic               last_q, last_nxt;
   logic               underrun_nxt, done_nxt;
   logic               tready_c;
   logic               tx_bit;

   // The bit on the wire always sits at the outgoing end of the shift register.
   // Advancing the register moves the next bit into that position.
   assign tx_bit          = MSB_FST ? shreg[DATA_W-1] : shreg[0];
   assign s_axis.s_tready = tready_c;
   assign busy            = (state != IDLE);

   // Next-state and counter logic. The timer is shared by SETUP and HOLD
   // because the two states never overlap. The ready signal is decoded only
   // from registered state and counters, so it never depends on tvalid in
   // the same cycle. The final phase of a non-last word accepts the next word
   // directly. This keeps consecutive words on the wire without a gap.
   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      phase_nxt    = phase;
      bit_nxt      = bit_cnt;
      shreg_nxt    = shreg;
      last_nxt     = last_q;
      underrun_nxt = 1'b0;
      done_nxt     = 1'b0;
      tready_c     = 1'b0;
      case (state)
         IDLE: begin
            tmr_nxt = '0;
            if (s_axis.s_tvalid) state_nxt = SETUP;
         end
         SETUP: begin
            if (tmr == SETUP_LAST) begin
               tmr_nxt   = '0;
               state_nxt = WAIT;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         WAIT: begin
            tready_c = 1'b1;
            if (s_axis.s_tvalid) begin
               shreg_nxt = s_axis.s_tdata;
               last_nxt  = s_axis.s_tlast;
               phase_nxt = '0;
               bit_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (phase != PH_LAST) begin
               phase_nxt = phase + 1'b1;
            end else begin
               phase_nxt = '0;
               if (bit_cnt != BIT_LAST) begin
                  bit_nxt   = bit_cnt + 1'b1;
                  shreg_nxt = MSB_FST ? (shreg << 1) : (shreg >> 1);
               end else if (last_q) begin
                  tmr_nxt   = '0;
                  state_nxt = HOLD;
               end else begin
                  tready_c = 1'b1;
                  bit_nxt  = '0;
                  if (s_axis.s_tvalid) begin
                     shreg_nxt = s_axis.s_tdata;
                     last_nxt  = s_axis.s_tlast;
                  end else begin
                     underrun_nxt = 1'b1;
                     state_nxt    = WAIT;
                  end
               end
            end
         end
         HOLD: begin
            if (tmr == HOLD_LAST) begin
               tmr_nxt   = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and registered line outputs. The line outputs are decoded
   // from the current state and phase, so they lag the internal state by one
   // clock. This also keeps them free of glitches. In WAIT the data line keeps
   // the last bit it sent, so the receiver sees no spurious edge between words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tmr        <= '0;
         phase      <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         last_q     <= 1'b0;
         underrun   <= 1'b0;
         frame_done <= 1'b0;
         rs422_cs   <= 1'b1;
         rs422_clk  <= IDLE_CLK;
         rs422_data <= 1'b0;
      end else begin
         state      <= state_nxt;
         tmr        <= tmr_nxt;
         phase      <= phase_nxt;
         bit_cnt    <= bit_nxt;
         shreg      <= shreg_nxt;
         last_q     <= last_nxt;
         underrun   <= underrun_nxt;
         frame_done <= done_nxt;
         rs422_cs   <= (state == IDLE);
         if (state == SHIFT) rs422_clk <= (phase < PH_HALF) ? ~IDLE_CLK : IDLE_CLK;
         else                rs422_clk <= IDLE_CLK;
         case (state)
            SHIFT:   rs422_data <= tx_bit;
            WAIT:    rs422_data <= rs422_data;
            default: rs422_data <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_rs422_tx_gen.sv
// tb_axis_rs422_tx_gen
// Directed bench for axis_rs422_tx_gen. The main instance uses the default
// test setup: 8-bit words, CLK_DIV 4, CS_SETUP 3, CS_HOLD 2, CPOL 1, MSB first.
// A second instance covers the 12-bit LSB-first configuration.
// The line monitors decode bits on each rising edge of rs422_clk. They also
// record the timing of cs and clock edges.
module tb_axis_rs422_tx_gen;

   logic clk;
   logic rst;
   int   cyc;
   int   test_cnt;
   int   fail_cnt;

   logic rs422_clk, rs422_cs, rs422_data, busy, underrun, frame_done;
   logic rs422_clk2, rs422_cs2, rs422_data2, busy2, underrun2, frame_done2;

   axis_rs422_tx_gen_if #(.DATA_W(8))  axis ();
   axis_rs422_tx_gen_if #(.DATA_W(12)) axis2 ();

   axis_rs422_tx_gen #(
      .DATA_W(8), .CLK_DIV(4), .CS_SETUP(3), .CS_HOLD(2), .MSB_FIRST(1), .CPOL(1)
   ) dut (
      .clk(clk), .rst(rst), .s_axis(axis),
      .rs422_clk(rs422_clk), .rs422_cs(rs422_cs), .rs422_data(rs422_data),
      .busy(busy), .underrun(underrun), .frame_done(frame_done)
   );

   axis_rs422_tx_gen #(
      .DATA_W(12), .CLK_DIV(4), .CS_SETUP(3), .CS_HOLD(2), .MSB_FIRST(0), .CPOL(1)
   ) dut2 (
      .clk(clk), .rst(rst), .s_axis(axis2),
      .rs422_clk(rs422_clk2), .rs422_cs(rs422_cs2), .rs422_data(rs422_data2),
      .busy(busy2), .underrun(underrun2), .frame_done(frame_done2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Main-instance line monitor. The initial block asks for a statistics
   // reset by bumping clear_seq. The monitor then performs the clear itself.
   // This way only the monitor writes its own counters.
   logic prev_clk = 1'b1, prev_cs = 1'b1, fall_data = 1'b0;
   int   clear_seq = 0, clear_seen = 0;
   logic bits[$];
   int   cs_fall_cyc, cs_rise_cyc, cs_rise_cnt, clk_fall_cyc, last_rise_cyc;
   int   unstable, gap_err, done_cnt, under_cnt, hs_cnt;
   bit   seen_fall, have_rise;

   always @(negedge clk) begin
      if (clear_seq != clear_seen) begin
         bits.delete();
         cs_rise_cnt = 0; unstable = 0; gap_err = 0;
         done_cnt = 0; under_cnt = 0; hs_cnt = 0;
         seen_fall = 1'b0; have_rise = 1'b0;
         clear_seen = clear_seq;
      end
      if (prev_cs === 1'b1 && rs422_cs === 1'b0) cs_fall_cyc = cyc;
      if (prev_cs === 1'b0 && rs422_cs === 1'b1) begin
         cs_rise_cyc = cyc;
         cs_rise_cnt++;
      end
      if (prev_clk === 1'b1 && rs422_clk === 1'b0) begin
         if (!seen_fall) begin
            clk_fall_cyc = cyc;
            seen_fall    = 1'b1;
         end
         fall_data = rs422_data;
      end
      if (prev_clk === 1'b0 && rs422_clk === 1'b1 && rs422_cs === 1'b0) begin
         bits.push_back(rs422_data);
         if (rs422_data !== fall_data) unstable++;
         if (have_rise && (cyc - last_rise_cyc) != 4) gap_err++;
         last_rise_cyc = cyc;
         have_rise     = 1'b1;
      end
      if (frame_done === 1'b1) done_cnt++;
      if (underrun === 1'b1) under_cnt++;
      if (axis.s_tvalid === 1'b1 && axis.s_tready === 1'b1) hs_cnt++;
      prev_clk = rs422_clk;
      prev_cs  = rs422_cs;
   end

   // Second-instance monitor. Only one frame is ever sent to it.
   logic prev_clk2 = 1'b1;
   logic bits2[$];
   int   done2 = 0, under2 = 0;

   always @(negedge clk) begin
      if (prev_clk2 === 1'b0 && rs422_clk2 === 1'b1 && rs422_cs2 === 1'b0)
         bits2.push_back(rs422_data2);
      if (frame_done2 === 1'b1) done2++;
      if (underrun2 === 1'b1) under2++;
      prev_clk2 = rs422_clk2;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      test_cnt++;
      if (observed !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Packs received bits in arrival order, so the first bit ends up in the
   // most significant position.
   function automatic logic [31:0] packBits(input logic q[$]);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = {v[30:0], q[i]};
      return v;
   endfunction

   task automatic clearStats();
      clear_seq++;
   endtask

   // Drive one word and wait, bounded, for the handshake. hs_cyc records
   // the cycle where tready was first seen.
   int hs_cyc;
   task automatic applyStimulus(input logic [7:0] word, input logic last);
      bit seen;
      seen            = 1'b0;
      axis.s_tvalid   = 1'b1;
      axis.s_tdata    = word;
      axis.s_tlast    = last;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (axis.s_tready === 1'b1) begin
            seen   = 1'b1;
            hs_cyc = cyc;
         end
      end
      @(posedge clk); #1;
      checkOutput("handshake", {31'd0, seen}, 32'd1);
   endtask

   task automatic applyStimulus12(input logic [11:0] word, input logic last);
      bit seen;
      seen           = 1'b0;
      axis2.s_tvalid = 1'b1;
      axis2.s_tdata  = word;
      axis2.s_tlast  = last;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (axis2.s_tready === 1'b1) seen = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput("handshake12", {31'd0, seen}, 32'd1);
   endtask

   task automatic waitDone(input bit second);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if ((second ? frame_done2 : frame_done) === 1'b1) seen = 1'b1;
      end
      checkOutput("frame_done_seen", {31'd0, seen}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   int  tv_cyc, rel_cyc, ref_cyc, gap_bad;
   bit  seen_u;

   initial begin
      test_cnt = 0; fail_cnt = 0; cyc = 0;
      rst = 1'b1;
      axis.s_tvalid = 1'b0; axis.s_tlast = 1'b0; axis.s_tdata = '0;
      axis2.s_tvalid = 1'b0; axis2.s_tlast = 1'b0; axis2.s_tdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_cs", {31'd0, rs422_cs}, 32'd1);
      checkOutput("rst_clk", {31'd0, rs422_clk}, 32'd1);
      checkOutput("rst_data", {31'd0, rs422_data}, 32'd0);
      checkOutput("rst_tready", {31'd0, axis.s_tready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
      checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);

      // Single word 0xA5 with tlast.
      @(posedge clk); #1;
      clearStats();
      tv_cyc = cyc;
      applyStimulus(8'hA5, 1'b1);
      axis.s_tvalid = 1'b0;
      checkOutput("a5_busy", {31'd0, busy}, 32'd1);
      waitDone(1'b0);
      checkOutput("a5_cs_fall", cs_fall_cyc - tv_cyc, 32'd2);
      checkOutput("a5_first_clk_low", clk_fall_cyc - cs_fall_cyc, 32'd4);
      checkOutput("a5_tready_delay", hs_cyc - tv_cyc, 32'd4);
      checkOutput("a5_bits", packBits(bits), 32'hA5);
      checkOutput("a5_pulses", bits.size(), 32'd8);
      checkOutput("a5_stable", unstable, 32'd0);
      checkOutput("a5_bit_period", gap_err, 32'd0);
      checkOutput("a5_cs_rise", cs_rise_cyc - last_rise_cyc, 32'd4);
      checkOutput("a5_done_cnt", done_cnt, 32'd1);
      checkOutput("a5_idle_busy", {31'd0, busy}, 32'd0);

      // Back-to-back 0x01, 0x80, 0xFF with tvalid continuous.
      @(posedge clk); #1;
      clearStats();
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h80, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      axis.s_tvalid = 1'b0;
      waitDone(1'b0);
      checkOutput("b2b_bits", packBits(bits), 32'h0180FF);
      checkOutput("b2b_pulses", bits.size(), 32'd24);
      checkOutput("b2b_gap", gap_err, 32'd0);
      checkOutput("b2b_handshakes", hs_cnt, 32'd3);
      checkOutput("b2b_underrun", under_cnt, 32'd0);
      checkOutput("b2b_done_cnt", done_cnt, 32'd1);

      // Underrun: 0x3C without tlast, a 10-cycle starvation gap, then 0xC3.
      @(posedge clk); #1;
      clearStats();
      applyStimulus(8'h3C, 1'b0);
      axis.s_tvalid = 1'b0;
      seen_u = 1'b0;
      for (int i = 0; i < 400 && !seen_u; i++) begin
         @(negedge clk);
         if (underrun === 1'b1) seen_u = 1'b1;
      end
      checkOutput("ur_pulse_seen", {31'd0, seen_u}, 32'd1);
      gap_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rs422_cs !== 1'b0 || rs422_clk !== 1'b1) gap_bad++;
      end
      checkOutput("ur_gap_lines", gap_bad, 32'd0);
      @(posedge clk); #1;
      applyStimulus(8'hC3, 1'b1);
      axis.s_tvalid = 1'b0;
      waitDone(1'b0);
      checkOutput("ur_count", under_cnt, 32'd1);
      checkOutput("ur_bits", packBits(bits), 32'h3CC3);
      checkOutput("ur_stable", unstable, 32'd0);
      checkOutput("ur_done_cnt", done_cnt, 32'd1);

      // Reset during bit 3 with tvalid held, then a fresh frame.
      @(posedge clk); #1;
      clearStats();
      applyStimulus(8'h96, 1'b1);
      axis.s_tvalid = 1'b0;
      for (int i = 0; i < 200 && bits.size() < 3; i++) @(negedge clk);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      axis.s_tvalid = 1'b1; axis.s_tdata = 8'h5A; axis.s_tlast = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rel_cyc = cyc;
      clearStats();
      @(negedge clk);
      checkOutput("mrst_cs", {31'd0, rs422_cs}, 32'd1);
      checkOutput("mrst_clk", {31'd0, rs422_clk}, 32'd1);
      checkOutput("mrst_data", {31'd0, rs422_data}, 32'd0);
      checkOutput("mrst_tready", {31'd0, axis.s_tready}, 32'd0);
      applyStimulus(8'h5A, 1'b1);
      axis.s_tvalid = 1'b0;
      checkOutput("mrst_full_setup", hs_cyc - rel_cyc, 32'd4);
      waitDone(1'b0);
      checkOutput("mrst_bits", packBits(bits), 32'h5A);
      checkOutput("mrst_done_cnt", done_cnt, 32'd1);

      // tvalid raised during HOLD: it must wait for IDLE plus a full SETUP.
      @(posedge clk); #1;
      clearStats();
      applyStimulus(8'hE7, 1'b1);
      axis.s_tvalid = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      ref_cyc = cyc;
      applyStimulus(8'h11, 1'b1);
      axis.s_tvalid = 1'b0;
      checkOutput("hold_tready_delay", hs_cyc - ref_cyc, 32'd6);
      checkOutput("hold_cs_released", cs_rise_cnt, 32'd1);
      checkOutput("hold_done_first", done_cnt, 32'd1);
      waitDone(1'b0);
      checkOutput("hold_bits", packBits(bits), 32'hE711);
      checkOutput("hold_done_cnt", done_cnt, 32'd2);

      // 12-bit LSB-first instance: 0x801 then 0x00C.
      @(posedge clk); #1;
      applyStimulus12(12'h801, 1'b0);
      applyStimulus12(12'h00C, 1'b1);
      axis2.s_tvalid = 1'b0;
      waitDone(1'b1);
      checkOutput("lsb_bits", packBits(bits2), 32'h801300);
      checkOutput("lsb_pulses", bits2.size(), 32'd24);
      checkOutput("lsb_done_cnt", done2, 32'd1);
      checkOutput("lsb_underrun", under2, 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
